mem_stage_access_unit: RTL and testbench

MEM-stage load/store controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access through a request/acknowledge handshake. It stalls the pipeline (holding EX/MEM and upstream) until the access completes. It also flags misaligned, out-of-range and timed-out accesses. It sits between the EX/MEM register outputs, the data memory and the MEM/WB register input.

---
 rtl/mem_stage_access_unit_if.sv | 25 ++
 rtl/mem_stage_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_stage_access_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and the data memory.
interface mem_stage_access_unit_if #(
  parameter int unsigned MEMORY_DEPTH = 32
);
  localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;

  // Access unit side: issues requests, receives completion.
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  // Memory side: receives requests, returns completion and load data.
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage load/store controller: checks the EX/MEM access, runs the memory
// handshake, stalls the pipeline until completion and flags access errors.
module mem_stage_access_unit #(
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read_i,
  input  logic                          mem_write_i,
  input  logic [31:0]                   alu_result_i,
  input  logic [31:0]                   read_data_2_i,
  mem_stage_access_unit_if.master       mem,
  output logic [31:0]                   read_data_o,
  output logic                          stall_o,
  output logic                          error_o,
  output logic [1:0]                    err_cause_o
);

  localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_RANGE      = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_err_q;

  logic [31:0]   offset_c;
  logic [31:0]   index_c;
  logic          mem_op_c;
  logic          misaligned_c;
  logic          out_of_range_c;
  logic          start_c;
  logic          idle_err_c;
  logic          last_cycle_c;

  // Address decode and access checks on the live EX/MEM values.
  always_comb begin
    offset_c       = alu_result_i - BASE_ADDR;
    index_c        = offset_c >> 2;
    mem_op_c       = mem_read_i | mem_write_i;
    misaligned_c   = (alu_result_i[1:0] != 2'b00);
    out_of_range_c = (alu_result_i < BASE_ADDR) || (index_c >= 32'(MEMORY_DEPTH));
    start_c        = (state_q == IDLE) && mem_op_c && !misaligned_c && !out_of_range_c;
    idle_err_c     = (state_q == IDLE) && mem_op_c && (misaligned_c || out_of_range_c);
    last_cycle_c   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Stall covers the detect cycle and every ACCESS cycle; both strobes are
  // gated by reset so they fall the instant reset is asserted.
  always_comb begin
    stall_o = reset & (start_c | (state_q == ACCESS));
    error_o = reset & (idle_err_c | timeout_err_q);
  end

  // Access FSM with registered memory-side outputs and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      timeout_err_q   <= 1'b0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      read_data_o     <= '0;
      err_cause_o     <= 2'b00;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q         <= ACCESS;
            cnt_q           <= '0;
            mem.mem_req_o   <= 1'b1;
            mem.mem_we_o    <= mem_write_i;
            mem.mem_addr_o  <= index_c[AW-1:0];
            mem.mem_wdata_o <= read_data_2_i;
          end else if (idle_err_c) begin
            err_cause_o <= misaligned_c ? CAUSE_MISALIGNED : CAUSE_RANGE;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem.mem_ack_i) begin
            state_q       <= DONE;
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) begin
              read_data_o <= mem.mem_rdata_i;
            end
          end else if (last_cycle_c) begin
            state_q       <= DONE;
            mem.mem_req_o <= 1'b0;
            read_data_o   <= '0;
            timeout_err_q <= 1'b1;
            err_cause_o   <= CAUSE_TIMEOUT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q       <= IDLE;
          mem.mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed testbench for mem_stage_access_unit.
module tb_mem_stage_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] alu_result_i;
  logic [31:0] read_data_2_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        error_o;
  logic [1:0]  err_cause_o;

  mem_stage_access_unit_if #(.MEMORY_DEPTH(32)) bus ();

  mem_stage_access_unit #(
    .MEMORY_DEPTH  (32),
    .BASE_ADDR     (32'h1001_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .alu_result_i (alu_result_i),
    .read_data_2_i(read_data_2_i),
    .mem          (bus),
    .read_data_o  (read_data_o),
    .stall_o      (stall_o),
    .error_o      (error_o),
    .err_cause_o  (err_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-operation observations collected by do_op.
  int          cycles;
  int          stall_cnt;
  int          n_req;
  int          err_pulses;
  logic        last_err;
  logic [4:0]  cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_end;
  int          pair_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one EX/MEM op (called #1 after a rising edge), act as memory acking
  // in ACCESS cycle ack_at (0 = never), run until the first non-stall cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
    logic done;
    done          = 1'b0;
    mem_read_i    = rd;
    mem_write_i   = wr;
    alu_result_i  = addr;
    read_data_2_i = wdata;
    cycles = 0; stall_cnt = 0; n_req = 0; err_pulses = 0; last_err = 1'b0;
    cap_addr = '0; cap_we = 1'b0; cap_wdata = '0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (stall_o) stall_cnt++;
      if (error_o) err_pulses++;
      last_err  = error_o;
      rdata_end = read_data_o;
      if (bus.mem_req_o) begin
        n_req++;
        if (n_req == 1) begin
          cap_addr  = bus.mem_addr_o;
          cap_we    = bus.mem_we_o;
          cap_wdata = bus.mem_wdata_o;
        end
        if (n_req == ack_at) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = rdata;
        end
      end
      if (!stall_o) begin
        done = 1'b1;
      end else if (cycles >= 64) begin
        checks++;
        errors++;
        $error("FAIL op_bound: observed=%0d cycles expected=<64", cycles);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.mem_ack_i = 1'b0;
    end
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    alu_result_i = '0; read_data_2_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;

    #3;
    check("rst_req",    32'(bus.mem_req_o),  32'd0);
    check("rst_we",     32'(bus.mem_we_o),   32'd0);
    check("rst_addr",   32'(bus.mem_addr_o), 32'd0);
    check("rst_wdata",  bus.mem_wdata_o,     32'd0);
    check("rst_rdata",  read_data_o,         32'd0);
    check("rst_err",    32'(error_o),        32'd0);
    check("rst_cause",  32'(err_cause_o),    32'd0);
    check("rst_stall",  32'(stall_o),        32'd0);

    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Zero-wait load
    do_op(1'b1, 1'b0, 32'h1001_0008, 32'h0, 1, 32'hCAFE_F00D);
    check("ld0_cycles", 32'(cycles),    32'd3);
    check("ld0_stall",  32'(stall_cnt), 32'd2);
    check("ld0_req",    32'(n_req),     32'd1);
    check("ld0_addr",   32'(cap_addr),  32'd2);
    check("ld0_we",     32'(cap_we),    32'd0);
    check("ld0_rdata",  rdata_end,      32'hCAFE_F00D);
    check("ld0_err",    32'(err_pulses), 32'd0);

    // Store, ack in third ACCESS cycle
    do_op(1'b0, 1'b1, 32'h1001_007C, 32'h1234_5678, 3, 32'hFFFF_FFFF);
    check("st_stall",  32'(stall_cnt), 32'd4);
    check("st_req",    32'(n_req),     32'd3);
    check("st_addr",   32'(cap_addr),  32'd31);
    check("st_we",     32'(cap_we),    32'd1);
    check("st_wdata",  cap_wdata,      32'h1234_5678);
    check("st_rdata",  rdata_end,      32'hCAFE_F00D);

    // Misaligned load
    do_op(1'b1, 1'b0, 32'h1001_0006, 32'h0, 1, 32'h0);
    check("mis_cycles", 32'(cycles),     32'd1);
    check("mis_err",    32'(err_pulses), 32'd1);
    check("mis_req",    32'(n_req),      32'd0);
    check("mis_stall",  32'(stall_cnt),  32'd0);
    check("mis_cause",  32'(err_cause_o), 32'd1);
    @(negedge clk);
    check("mis_err_1w", 32'(error_o),    32'd0);
    check("mis_rdata",  read_data_o,     32'hCAFE_F00D);
    @(posedge clk); #1;

    // Below base address
    do_op(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 1, 32'h0);
    check("low_err",   32'(err_pulses),  32'd1);
    check("low_req",   32'(n_req),       32'd0);
    check("low_cause", 32'(err_cause_o), 32'd2);

    // Misaligned and out of range: misaligned wins
    do_op(1'b0, 1'b1, 32'h1001_0081, 32'h0, 1, 32'h0);
    check("prio_cause", 32'(err_cause_o), 32'd1);

    // One word past the end
    do_op(1'b1, 1'b0, 32'h1001_0080, 32'h0, 1, 32'h0);
    check("oor_err",   32'(err_pulses),  32'd1);
    check("oor_req",   32'(n_req),       32'd0);
    check("oor_stall", 32'(stall_cnt),   32'd0);
    check("oor_cause", 32'(err_cause_o), 32'd2);

    // Timeout: ack never arrives
    do_op(1'b1, 1'b0, 32'h1001_0000, 32'h0, 0, 32'h0);
    check("to_req",    32'(n_req),       32'd16);
    check("to_stall",  32'(stall_cnt),   32'd17);
    check("to_errs",   32'(err_pulses),  32'd1);
    check("to_err_dn", 32'(last_err),    32'd1);
    check("to_rdata",  rdata_end,        32'd0);
    check("to_cause",  32'(err_cause_o), 32'd3);
    @(negedge clk);
    check("to_idle",   32'(stall_o),     32'd0);
    @(posedge clk); #1;

    // Read and write both set: write performed
    do_op(1'b1, 1'b1, 32'h1001_0004, 32'hA5A5_A5A5, 1, 32'h1111_1111);
    check("rw_we",    32'(cap_we),   32'd1);
    check("rw_addr",  32'(cap_addr), 32'd1);
    check("rw_wdata", cap_wdata,     32'hA5A5_A5A5);
    check("rw_rdata", rdata_end,     32'd0);

    // Stray ack in IDLE
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_req",   32'(bus.mem_req_o), 32'd0);
    check("stray_stall", 32'(stall_o),       32'd0);
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    check("stray_rdata", read_data_o, 32'd0);
    @(posedge clk); #1;

    // Back-to-back zero-wait loads
    do_op(1'b1, 1'b0, 32'h1001_0010, 32'h0, 1, 32'h0101_0101);
    pair_cycles = cycles;
    check("b2b_a_addr",  32'(cap_addr), 32'd4);
    check("b2b_a_rdata", rdata_end,     32'h0101_0101);
    do_op(1'b1, 1'b0, 32'h1001_0014, 32'h0, 1, 32'h0202_0202);
    pair_cycles += cycles;
    check("b2b_b_addr",  32'(cap_addr),    32'd5);
    check("b2b_b_stall", 32'(stall_cnt),   32'd2);
    check("b2b_b_rdata", rdata_end,        32'h0202_0202);
    check("b2b_total",   32'(pair_cycles), 32'd6);

    // Reset during the second ACCESS cycle
    mem_read_i = 1'b1; alu_result_i = 32'h1001_0020; read_data_2_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_pre", 32'(bus.mem_req_o), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_req",   32'(bus.mem_req_o),  32'd0);
    check("mid_stall", 32'(stall_o),        32'd0);
    check("mid_addr",  32'(bus.mem_addr_o), 32'd0);
    check("mid_rdata", read_data_o,         32'd0);
    check("mid_cause", 32'(err_cause_o),    32'd0);
    check("mid_err",   32'(error_o),        32'd0);
    mem_read_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_req",   32'(bus.mem_req_o), 32'd0);
    check("post_stall", 32'(stall_o),       32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 32'h1001_0020, 32'h0, 1, 32'h0000_0077);
    check("post_ld_stall", 32'(stall_cnt), 32'd2);
    check("post_ld_addr",  32'(cap_addr),  32'd8);
    check("post_ld_rdata", rdata_end,      32'h0000_0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
